// File: rtl/rx_polar_pkg.sv
// Shared types and helpers for the RX polar statistics blocks.
// Phase helpers work on up to 32-bit turn fractions.
package rx_polar_pkg;

  localparam int MW_DEF        = 16;
  localparam int PW_DEF        = 25;
  localparam int LOG2N_MAX_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    ACCUM = 2'd2
  } state_t;

  // (a - b) mod 2^pw, returned sign-extended so the shortest arc wins.
  function automatic logic signed [31:0] wrap_diff(input logic [31:0] a,
                                                   input logic [31:0] b,
                                                   input int unsigned pw);
    logic [31:0] diff;
    diff = a - b;
    return $signed(diff << (32 - pw)) >>> (32 - pw);
  endfunction

  function automatic logic [3:0] clamp_log2n(input logic [3:0]  log2n,
                                             input int unsigned max_log2n);
    if (32'(log2n) > max_log2n) return max_log2n[3:0];
    return log2n;
  endfunction

endpackage

// File: rtl/rx_avg_result_reg.sv
// Result holding register with valid/ready handshake, overwrite-on-completion
// and a sticky overrun flag for results lost before the consumer took them.
module rx_avg_result_reg #(
  parameter int W = 8
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  input  logic         clr_overrun,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         overrun
);

  logic lost;

  assign lost = load && valid && !ready;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    // NOTE: the payload is reset as well, so every output reads 0 after reset
    // rather than whatever the flops powered up with.
    if (!rst_n) begin
      valid   <= 1'b0;
      data    <= '0;
      overrun <= 1'b0;
    end else begin
      if (load) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      // A new loss outranks a clear arriving in the same cycle.
      if (lost)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_polar_averager.sv
// Block averager for the decimated magnitude/phase stream: one mean magnitude,
// circular-mean phase and phase drift per block of 2^k samples.
module rx_polar_averager
  import rx_polar_pkg::*;
#(
  parameter int MW        = MW_DEF,
  parameter int PW        = PW_DEF,
  parameter int LOG2N_MAX = LOG2N_MAX_DEF
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          i_ce,
  input  logic [MW-1:0] i_mag,
  input  logic [PW-1:0] i_phase,
  input  logic          i_enable,
  input  logic [3:0]    i_log2n,
  input  logic          i_ready,
  input  logic          i_clr_overrun,
  output logic          o_valid,
  output logic [MW-1:0] o_mag_avg,
  output logic [PW-1:0] o_phase_avg,
  output logic [PW-1:0] o_phase_delta,
  output logic          o_overrun,
  output logic          o_busy
);

  localparam int MAW = MW + LOG2N_MAX;
  localparam int PAW = PW + LOG2N_MAX;
  localparam int CW  = LOG2N_MAX + 1;
  localparam int RW  = MW + 2 * PW;

  state_t state, state_nxt;

  logic [3:0]            k_eff;
  logic [PW-1:0]         ref_phase;
  logic signed [MAW-1:0] mag_acc;
  logic signed [PAW-1:0] ph_acc;
  logic [CW-1:0]         cnt;

  logic                  take_first;
  logic                  take_accum;
  logic                  done;
  logic [3:0]            k_cur;
  logic [PW-1:0]         base_phase;
  logic signed [MAW-1:0] mag_sum;
  logic signed [PAW-1:0] ph_sum;
  logic [CW-1:0]         cnt_nxt;
  logic [MW-1:0]         res_mag;
  logic [PW-1:0]         res_phase;
  logic [PW-1:0]         res_delta;
  logic [RW-1:0]         res_q;

  assign take_first = (state == FIRST) && i_enable && i_ce;
  assign take_accum = (state == ACCUM) && i_enable && i_ce;

  // The first sample of a block supplies its own k and reference, so the
  // sums below are formed from the live inputs rather than the registers.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    k_cur      = k_eff;
    base_phase = ref_phase;
    mag_sum    = mag_acc;
    ph_sum     = ph_acc;
    cnt_nxt    = cnt;
    if (take_first) begin
      k_cur      = clamp_log2n(i_log2n, LOG2N_MAX);
      base_phase = i_phase;
      mag_sum    = MAW'($signed(i_mag));
      ph_sum     = '0;
      cnt_nxt    = CW'(1);
    end else if (take_accum) begin
      mag_sum = mag_acc + MAW'($signed(i_mag));
      ph_sum  = ph_acc + PAW'(wrap_diff(32'(i_phase), 32'(ref_phase), PW));
      cnt_nxt = cnt + CW'(1);
    end
  end

  assign done = (take_first || take_accum) && (cnt_nxt == (CW'(1) << k_cur));

  // Truncating the shifted sums keeps the mean mod 2^PW, which is exactly the
  // wrap needed when the average is re-anchored to the reference phase.
  assign res_mag   = MW'(mag_sum >>> k_cur);
  assign res_phase = base_phase + PW'(ph_sum >>> k_cur);
  assign res_delta = i_phase - base_phase;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_enable) state_nxt = FIRST;
      FIRST:   if (!i_enable)              state_nxt = IDLE;
               else if (take_first && !done) state_nxt = ACCUM;
      ACCUM:   if (!i_enable) state_nxt = IDLE;
               else if (done) state_nxt = FIRST;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    // NOTE: state and datapath registers use non-blocking assignments so all
    // of them update from the same pre-edge values.
    if (!rst_n) begin
      state     <= IDLE;
      k_eff     <= '0;
      ref_phase <= '0;
      mag_acc   <= '0;
      ph_acc    <= '0;
      cnt       <= '0;
    end else begin
      state <= state_nxt;
      if (take_first || take_accum) begin
        mag_acc <= mag_sum;
        ph_acc  <= ph_sum;
        cnt     <= cnt_nxt;
      end
      if (take_first) begin
        k_eff     <= k_cur;
        ref_phase <= i_phase;
      end
    end
  end

  rx_avg_result_reg #(
    .W (RW)
  ) u_result (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .load        (done),
    .load_data   ({res_mag, res_phase, res_delta}),
    .ready       (i_ready),
    .clr_overrun (i_clr_overrun),
    .valid       (o_valid),
    .data        (res_q),
    .overrun     (o_overrun)
  );

  assign o_mag_avg     = res_q[RW-1 -: MW];
  assign o_phase_avg   = res_q[2*PW-1 -: PW];
  assign o_phase_delta = res_q[PW-1:0];
  assign o_busy        = (state == ACCUM);

endmodule
